wb_stage_param: RTL and testbench

WB_STAGE_PARAM -- requirements
Module: wb_stage_param

---
 rtl/wb_stage_param.sv | 136 +++++++++++++
 tb/tb_wb_stage_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// Write-back stage with a small committed-write history for operand forwarding.
// The wb_* register feeds the register file one cycle after the MEM/WB entry
// is sampled. Every committed write also enters a HIST_DEPTH-deep shift
// register. NUM_RD lookup ports search that history combinationally.
// Legal parameter ranges: HIST_DEPTH 1..8, NUM_RD 1..4.
module wb_stage_param #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 2,
  parameter int NUM_RD     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_in,
  input  logic                       flush_in,
  input  logic                       memwb_valid_in,
  input  logic [REG_AW-1:0]          memwb_reg_in,
  input  logic [DATA_W-1:0]          memwb_data_in,
  output logic                       wb_valid_out,
  output logic [REG_AW-1:0]          wb_reg_out,
  output logic [DATA_W-1:0]          wb_data_out,
  input  logic [NUM_RD*REG_AW-1:0]   fwd_addr_in,
  output logic [NUM_RD-1:0]          fwd_hit_out,
  output logic [NUM_RD*DATA_W-1:0]   fwd_data_out,
  output logic [31:0]                retire_count_out
);

  // Write-back register
  logic                               wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0]                  wb_reg_q,   wb_reg_d;
  logic [DATA_W-1:0]                  wb_data_q,  wb_data_d;

  // History, entry 0 is the newest committed write
  logic [HIST_DEPTH-1:0]              hist_vld_q,  hist_vld_d;
  logic [HIST_DEPTH-1:0][REG_AW-1:0]  hist_reg_q,  hist_reg_d;
  logic [HIST_DEPTH-1:0][DATA_W-1:0]  hist_data_q, hist_data_d;

  logic [31:0]                        retire_cnt_q, retire_cnt_d;

  logic                               capture;
  logic                               commit;

  // A capture happens only when neither flush nor stall is active; a commit is
  // a capture that really writes a non-zero register.
  assign capture = !flush_in && !stall_in;
  assign commit  = capture && memwb_valid_in && (memwb_reg_in != '0);

  // Next-state: flush beats stall, stall beats capture.
  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;
    hist_vld_d   = hist_vld_q;
    hist_reg_d   = hist_reg_q;
    hist_data_d  = hist_data_q;
    retire_cnt_d = retire_cnt_q;

    if (flush_in) begin
      // Squash only the write-back register; history and counter keep their state.
      wb_valid_d = 1'b0;
      wb_reg_d   = '0;
      wb_data_d  = '0;
    end else if (capture) begin
      wb_valid_d = memwb_valid_in && (memwb_reg_in != '0);
      wb_reg_d   = memwb_reg_in;
      wb_data_d  = memwb_data_in;
      if (commit) begin
        for (int i = HIST_DEPTH - 1; i >= 1; i--) begin
          hist_vld_d[i]  = hist_vld_q[i-1];
          hist_reg_d[i]  = hist_reg_q[i-1];
          hist_data_d[i] = hist_data_q[i-1];
        end
        hist_vld_d[0]  = 1'b1;
        hist_reg_d[0]  = memwb_reg_in;
        hist_data_d[0] = memwb_data_in;
        retire_cnt_d   = retire_cnt_q + 32'd1;
      end
    end
  end

  // State registers with asynchronous clear; a stalled entry is simply lost on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q   <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      hist_vld_q   <= '0;
      hist_reg_q   <= '0;
      hist_data_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_reg_q     <= wb_reg_d;
      wb_data_q    <= wb_data_d;
      hist_vld_q   <= hist_vld_d;
      hist_reg_q   <= hist_reg_d;
      hist_data_q  <= hist_data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_valid_out     = wb_valid_q;
  assign wb_reg_out       = wb_reg_q;
  assign wb_data_out      = wb_data_q;
  assign retire_count_out = retire_cnt_q;

  logic [NUM_RD-1:0]             fwd_hit_c;
  logic [NUM_RD-1:0][DATA_W-1:0] fwd_data_c;
  logic [NUM_RD-1:0][REG_AW-1:0] fwd_addr_c;

  // Forwarding lookup: scan oldest to newest so the newest match wins. Only
  // registered history is searched, never the incoming memwb_* entry.
  always_comb begin
    fwd_hit_c  = '0;
    fwd_data_c = '0;
    fwd_addr_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      fwd_addr_c[k] = fwd_addr_in[k*REG_AW +: REG_AW];
      for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
        if (hist_vld_q[i] && (hist_reg_q[i] == fwd_addr_c[k])) begin
          fwd_hit_c[k]  = 1'b1;
          fwd_data_c[k] = hist_data_q[i];
        end
      end
      // Register 0 never forwards, and nothing forwards while reset is held.
      if ((fwd_addr_c[k] == '0) || reset) begin
        fwd_hit_c[k]  = 1'b0;
        fwd_data_c[k] = '0;
      end
    end
  end

  assign fwd_hit_out  = fwd_hit_c;
  assign fwd_data_out = fwd_data_c;

endmodule

// File: tb/tb_wb_stage_param.sv
// Directed bench for wb_stage_param with default parameters
// (DATA_W=32, REG_AW=5, HIST_DEPTH=2, NUM_RD=2).
module tb_wb_stage_param;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        flush_in;
  logic        memwb_valid_in;
  logic [4:0]  memwb_reg_in;
  logic [31:0] memwb_data_in;
  logic        wb_valid_out;
  logic [4:0]  wb_reg_out;
  logic [31:0] wb_data_out;
  logic [9:0]  fwd_addr_in;
  logic [1:0]  fwd_hit_out;
  logic [63:0] fwd_data_out;
  logic [31:0] retire_count_out;

  int checks = 0;
  int errors = 0;

  wb_stage_param dut (
    .clk              (clk),
    .reset            (reset),
    .stall_in         (stall_in),
    .flush_in         (flush_in),
    .memwb_valid_in   (memwb_valid_in),
    .memwb_reg_in     (memwb_reg_in),
    .memwb_data_in    (memwb_data_in),
    .wb_valid_out     (wb_valid_out),
    .wb_reg_out       (wb_reg_out),
    .wb_data_out      (wb_data_out),
    .fwd_addr_in      (fwd_addr_in),
    .fwd_hit_out      (fwd_hit_out),
    .fwd_data_out     (fwd_data_out),
    .retire_count_out (retire_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
    memwb_valid_in = v;
    memwb_reg_in   = r;
    memwb_data_in  = d;
  endtask

  task automatic set_fwd(input logic [4:0] a0, input logic [4:0] a1);
    fwd_addr_in = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    drive(1'b1, 5'd3, 32'h1234);
    set_fwd(5'd3, 5'd0);
    step();
    checks++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== 38'd0) begin
      errors++; $display("FAIL reset_wb got %b/%0d/%h exp 0/0/0", wb_valid_out, wb_reg_out, wb_data_out);
    end
    checks++;
    if (retire_count_out !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %h exp 0", retire_count_out);
    end
    checks++;
    if (fwd_hit_out !== 2'b00) begin
      errors++; $display("FAIL reset_hit got %b exp 00", fwd_hit_out);
    end
    drive(1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_write();
    drive(1'b1, 5'd3, 32'h0000000F);
    step();
    drive(1'b0, 5'd0, 32'd0);
    set_fwd(5'd3, 5'd4);
    checks++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd3, 32'hF}) begin
      errors++; $display("FAIL basic_wb got %b/%0d/%h exp 1/3/f", wb_valid_out, wb_reg_out, wb_data_out);
    end
    checks++;
    if (retire_count_out !== 32'd1) begin
      errors++; $display("FAIL basic_cnt got %0d exp 1", retire_count_out);
    end
    checks++;
    if (fwd_hit_out[0] !== 1'b1 || fwd_data_out[31:0] !== 32'hF) begin
      errors++; $display("FAIL basic_fwd0 got %b/%h exp 1/f", fwd_hit_out[0], fwd_data_out[31:0]);
    end
    checks++;
    if (fwd_hit_out[1] !== 1'b0 || fwd_data_out[63:32] !== 32'h0) begin
      errors++; $display("FAIL basic_fwd1_miss got %b/%h exp 0/0", fwd_hit_out[1], fwd_data_out[63:32]);
    end
  endtask

  task automatic test_reg0();
    drive(1'b1, 5'd0, 32'hDEADBEEF);
    step();
    set_fwd(5'd0, 5'd3);
    checks++;
    if (wb_valid_out !== 1'b0 || wb_reg_out !== 5'd0 || wb_data_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reg0_wb got %b/%0d/%h exp 0/0/deadbeef", wb_valid_out, wb_reg_out, wb_data_out);
    end
    checks++;
    if (retire_count_out !== 32'd1) begin
      errors++; $display("FAIL reg0_cnt got %0d exp 1", retire_count_out);
    end
    checks++;
    if (fwd_hit_out !== 2'b10 || fwd_data_out !== {32'hF, 32'h0}) begin
      errors++; $display("FAIL reg0_fwd got %b/%h exp 10/0000000f00000000", fwd_hit_out, fwd_data_out);
    end
    drive(1'b0, 5'd6, 32'h66);
    step();
    set_fwd(5'd6, 5'd3);
    checks++;
    if (wb_valid_out !== 1'b0 || wb_reg_out !== 5'd6 || retire_count_out !== 32'd1 || fwd_hit_out !== 2'b10) begin
      errors++; $display("FAIL invalid_entry got v=%b r=%0d cnt=%0d hit=%b exp v=0 r=6 cnt=1 hit=10",
                         wb_valid_out, wb_reg_out, retire_count_out, fwd_hit_out);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd5, 32'h11);
    step();
    drive(1'b1, 5'd5, 32'h22);
    step();
    set_fwd(5'd5, 5'd3);
    checks++;
    if (fwd_hit_out !== 2'b01 || fwd_data_out !== {32'h0, 32'h22} || retire_count_out !== 32'd3) begin
      errors++; $display("FAIL prio_newest got hit=%b data=%h cnt=%0d exp 01/22/3",
                         fwd_hit_out, fwd_data_out, retire_count_out);
    end
    drive(1'b1, 5'd7, 32'h33);
    step();
    drive(1'b1, 5'd9, 32'h99);
    set_fwd(5'd5, 5'd7);
    checks++;
    if (fwd_hit_out !== 2'b11 || fwd_data_out !== {32'h33, 32'h22} || retire_count_out !== 32'd4) begin
      errors++; $display("FAIL prio_evict got hit=%b data=%h cnt=%0d exp 11/0000003300000022/4",
                         fwd_hit_out, fwd_data_out, retire_count_out);
    end
    set_fwd(5'd9, 5'd5);
    checks++;
    if (fwd_hit_out !== 2'b10) begin
      errors++; $display("FAIL no_bypass got hit=%b exp 10", fwd_hit_out);
    end
  endtask

  task automatic test_stall_flush();
    stall_in = 1'b1; flush_in = 1'b1;
    drive(1'b1, 5'd9, 32'h5);
    step();
    set_fwd(5'd9, 5'd7);
    checks++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== 38'd0 || retire_count_out !== 32'd4) begin
      errors++; $display("FAIL stall_flush got %b/%0d/%h cnt=%0d exp 0/0/0 cnt=4",
                         wb_valid_out, wb_reg_out, wb_data_out, retire_count_out);
    end
    checks++;
    if (fwd_hit_out !== 2'b10 || fwd_data_out[63:32] !== 32'h33) begin
      errors++; $display("FAIL flush_hist got hit=%b data=%h exp 10/33", fwd_hit_out, fwd_data_out[63:32]);
    end
    stall_in = 1'b0; flush_in = 1'b0;
    drive(1'b1, 5'd10, 32'hAB);
    step();
    stall_in = 1'b1;
    drive(1'b1, 5'd11, 32'h77);
    for (int c = 0; c < 3; c++) begin
      step();
      set_fwd(5'd11, 5'd10);
      checks++;
      if ({wb_valid_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd10, 32'hAB} || retire_count_out !== 32'd5
          || fwd_hit_out !== 2'b10 || fwd_data_out[63:32] !== 32'hAB) begin
        errors++; $display("FAIL stall_hold cyc%0d got %b/%0d/%h cnt=%0d hit=%b exp 1/10/ab cnt=5 hit=10",
                           c, wb_valid_out, wb_reg_out, wb_data_out, retire_count_out, fwd_hit_out);
      end
    end
    stall_in = 1'b0;
    step();
    checks++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd11, 32'h77} || retire_count_out !== 32'd6) begin
      errors++; $display("FAIL stall_release got %b/%0d/%h cnt=%0d exp 1/11/77 cnt=6",
                         wb_valid_out, wb_reg_out, wb_data_out, retire_count_out);
    end
  endtask

  task automatic test_async_reset();
    stall_in = 1'b1;
    drive(1'b1, 5'd13, 32'h13);
    step();
    set_fwd(5'd11, 5'd10);
    reset = 1'b1;
    #1;
    checks++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== 38'd0 || retire_count_out !== 32'd0) begin
      errors++; $display("FAIL async_reset got %b/%0d/%h cnt=%0d exp 0/0/0 cnt=0",
                         wb_valid_out, wb_reg_out, wb_data_out, retire_count_out);
    end
    checks++;
    if (fwd_hit_out !== 2'b00 || fwd_data_out !== 64'd0) begin
      errors++; $display("FAIL async_reset_fwd got %b/%h exp 00/0", fwd_hit_out, fwd_data_out);
    end
    step();
    stall_in = 1'b0;
    reset = 1'b0;
    drive(1'b1, 5'd12, 32'h12);
    step();
    drive(1'b0, 5'd0, 32'd0);
    set_fwd(5'd12, 5'd13);
    checks++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd12, 32'h12} || retire_count_out !== 32'd1
        || fwd_hit_out !== 2'b01) begin
      errors++; $display("FAIL post_reset got %b/%0d/%h cnt=%0d hit=%b exp 1/12/12 cnt=1 hit=01",
                         wb_valid_out, wb_reg_out, wb_data_out, retire_count_out, fwd_hit_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 2), vals[i]);
      step();
      checks++;
      if ({wb_valid_out, wb_reg_out, wb_data_out} !== {1'b1, 5'(i + 2), vals[i]} || retire_count_out !== 32'(i + 2)) begin
        errors++; $display("FAIL b2b_%0d got %b/%0d/%h cnt=%0d exp 1/%0d/%h cnt=%0d",
                           i, wb_valid_out, wb_reg_out, wb_data_out, retire_count_out, i + 2, vals[i], i + 2);
      end
    end
    drive(1'b0, 5'd0, 32'd0);
    set_fwd(5'd4, 5'd2);
    checks++;
    if (fwd_hit_out !== 2'b01 || fwd_data_out !== {32'h0, 32'hC}) begin
      errors++; $display("FAIL b2b_fwd_a got %b/%h exp 01/c", fwd_hit_out, fwd_data_out);
    end
    set_fwd(5'd3, 5'd12);
    checks++;
    if (fwd_hit_out !== 2'b01 || fwd_data_out !== {32'h0, 32'hB}) begin
      errors++; $display("FAIL b2b_fwd_b got %b/%h exp 01/b", fwd_hit_out, fwd_data_out);
    end
  endtask

  task automatic test_counter_wrap();
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    checks++;
    if (retire_count_out !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL wrap_preload got %h exp ffffffff", retire_count_out);
    end
    drive(1'b1, 5'd1, 32'h1);
    step();
    drive(1'b0, 5'd0, 32'd0);
    checks++;
    if (retire_count_out !== 32'd0 || wb_valid_out !== 1'b1) begin
      errors++; $display("FAIL wrap got cnt=%h v=%b exp 0/1", retire_count_out, wb_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_reg0();
    test_priority();
    test_stall_flush();
    test_async_reset();
    test_back_to_back();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
